fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage feeding the instruction ROM and the decode stage.
//  Holds the PC, drives rom address combinationally and captures rom data_out
//  (same-cycle read) with its PC into a small prefetch FIFO.
//  Presents {inst, inst_pc} to decode over a valid/ready handshake.
//  Handles redirects (branch/jump/trap) by flushing the FIFO.
// PARAMETERS
//  RESET_PC    32'h0  PC loaded on reset (IMemAddrT, word aligned)
//  FIFO_DEPTH  2      prefetch entries, power of two, >=2
// PORTS
//  clk              in   1              clock, all state on rising edge
//  reset            in   1              synchronous, active-high
//  rom_address      out  IMemAddrWidth  to rom address (IMemAddrT) = pc
//  rom_data         in   32             from rom data_out (IMemDataT)
//  redirect         in   1              load redirect_pc, flush FIFO
//  redirect_pc      in   IMemAddrWidth  redirect target
//  inst_valid       out  1              FIFO head valid
//  inst_ready       in   1              decode accepts head
//  inst             out  32             head instruction word
//  inst_pc          out  IMemAddrWidth  head PC
//  fetch_misaligned out  1              1-cycle pulse, misaligned redirect
// BEHAVIOUR
//  - Reset: pc=RESET_PC, FIFO empty, inst_valid=0, inst=0, inst_pc=0,
//    fetch_misaligned=0, halted=0. Reset overrides every other input.
//  - rom_address = pc, combinational from the pc register.
//  - pop = inst_valid & inst_ready; push = !redirect & !halted &
//    (count<FIFO_DEPTH | pop). Push writes {rom_data, pc}; pc <= pc+4.
//  - Full with simultaneous pop: push allowed, count unchanged.
//  - Empty: inst_valid=0, inst/inst_pc hold last head value (don't care).
//  - Latency: first word pushed in the first cycle after reset deasserts;
//    inst_valid=1 one cycle later. Throughput 1 inst/cycle with ready=1.
//  - FIFO outputs are registered head (no combinational rom->inst path).
//  - redirect (highest priority after reset): FIFO cleared, count=0,
//    pc <= redirect_pc, no push and no pop that cycle; inst_valid=0 next
//    cycle; first post-redirect word valid two cycles after redirect.
//  - Back-to-back redirects: last one wins, each flushes.
//  - PC arithmetic modulo 2^IMemAddrWidth: pc at max word wraps to 0.
//  - count width $clog2(FIFO_DEPTH)+1; rd/wr pointers wrap naturally.
//  - inst_ready while inst_valid=0 has no effect.
// CONFIGURATION
//  FETCH_ALIGN_CHECK_EN defined:
//   - redirect with redirect_pc[1:0]!=0: FIFO flushed, pc loaded unchanged,
//     fetch_misaligned=1 for exactly the next cycle, halted=1 (no pushes).
//   - halted cleared only by an aligned redirect or reset.
//  FETCH_ALIGN_CHECK_EN undefined:
//   - redirect_pc[1:0] forced to 2'b00 on load; fetch_misaligned tied 0;
//     no halted state.
// TESTING
//  1 Reset, RESET_PC=0, ready=1, rom[k]=k -> inst_valid rises 2nd cycle
//    after reset low; inst_pc 0,4,8,... with inst 0,1,2,... one per cycle.
//  2 ready=0 for 5 cycles -> FIFO fills to 2, rom_address stalls at 8;
//    ready=1 -> pcs 0,4,8,12 delivered in order, none lost/duplicated.
//  3 redirect to 0x40 while FIFO full -> inst_valid=0 next cycle;
//    next delivered inst_pc=0x40, stale 0x8/0xC never appear.
//  4 reset asserted mid-stream with FIFO full -> next cycle inst_valid=0,
//    rom_address=RESET_PC.
//  5 redirect to top word (2^IMemAddrWidth-4) -> delivered pcs wrap to 0.
//  6 EN defined: redirect 0x42 -> fetch_misaligned=1 one cycle, no valid
//    until redirect 0x80; undefined: redirect 0x42 -> inst_pc=0x40.

Source files
------------

// File: rtl/fetch_unit.sv
// Fetch stage: PC -> ROM address, registered prefetch FIFO of {inst, pc}; a word is valid one cycle after its push.
// Stalls when the FIFO is full and decode is not ready; redirects flush. FETCH_ALIGN_CHECK_EN enables misaligned-redirect trapping.
module fetch_unit #(
  parameter int                       IMemAddrWidth = 16,
  parameter logic [IMemAddrWidth-1:0] RESET_PC      = '0,
  parameter int                       FIFO_DEPTH    = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [IMemAddrWidth-1:0] rom_address,
  input  logic [31:0]              rom_data,
  input  logic                     redirect,
  input  logic [IMemAddrWidth-1:0] redirect_pc,
  output logic                     inst_valid,
  input  logic                     inst_ready,
  output logic [31:0]              inst,
  output logic [IMemAddrWidth-1:0] inst_pc,
  output logic                     fetch_misaligned
);

  localparam int PtrW = $clog2(FIFO_DEPTH);
  localparam int CntW = PtrW + 1;

  typedef struct packed {
    logic [31:0]              inst;
    logic [IMemAddrWidth-1:0] pc;
  } entry_t;

  entry_t                   r_mem [FIFO_DEPTH];
  logic [PtrW-1:0]          r_rd_ptr;
  logic [PtrW-1:0]          r_wr_ptr;
  logic [CntW-1:0]          r_count;
  logic [IMemAddrWidth-1:0] r_pc;

  logic                     w_pop;
  logic                     w_push;
  logic                     w_halted;
  logic [IMemAddrWidth-1:0] w_redirect_target;
  entry_t                   w_head;

`ifdef FETCH_ALIGN_CHECK_EN
  logic r_halted;
  logic r_misaligned;
  logic w_redirect_bad;

  assign w_redirect_bad    = (redirect_pc[1:0] != 2'b00);
  assign w_redirect_target = redirect_pc;
  assign w_halted          = r_halted;
  assign fetch_misaligned  = r_misaligned;

  // A misaligned target parks the stage until an aligned redirect arrives.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_halted     <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      r_misaligned <= redirect & w_redirect_bad;
      if (redirect) begin
        r_halted <= w_redirect_bad;
      end
    end
  end
`else
  assign w_redirect_target = redirect_pc & ~IMemAddrWidth'(3);
  assign w_halted          = 1'b0;
  assign fetch_misaligned  = 1'b0;
`endif

  assign rom_address = r_pc;
  assign w_head      = r_mem[r_rd_ptr];
  assign inst        = w_head.inst;
  assign inst_pc     = w_head.pc;
  assign inst_valid  = (r_count != '0);

  assign w_pop  = inst_valid & inst_ready;
  assign w_push = !redirect & !w_halted & ((r_count < CntW'(FIFO_DEPTH)) | w_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc     <= RESET_PC;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (redirect) begin
      r_pc     <= w_redirect_target;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      // When full, a same-cycle pop frees the slot the push overwrites.
      if (w_push) begin
        r_mem[r_wr_ptr] <= '{inst: rom_data, pc: r_pc};
        r_wr_ptr        <= r_wr_ptr + 1'b1;
        r_pc            <= r_pc + IMemAddrWidth'(4);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: cycle table of inputs and expected outputs plus redirect corner sequences.
module tb_fetch_unit;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  rom_address;
  logic [31:0]   rom_data;
  logic          redirect;
  logic [W-1:0]  redirect_pc;
  logic          inst_valid;
  logic          inst_ready;
  logic [31:0]   inst;
  logic [W-1:0]  inst_pc;
  logic          fetch_misaligned;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic         rst;
    logic         redir;
    logic [W-1:0] rpc;
    logic         rdy;
    logic         exp_vld;
    logic [W-1:0] exp_ipc;
    logic [W-1:0] exp_ra;
    logic         exp_mis;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  // ROM model: word k holds k.
  assign rom_data = 32'(rom_address >> 2);

  fetch_unit #(
    .IMemAddrWidth(W),
    .RESET_PC     (16'h0000),
    .FIFO_DEPTH   (2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .rom_address     (rom_address),
    .rom_data        (rom_data),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .fetch_misaligned(fetch_misaligned)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic redir, input logic [W-1:0] rpc, input logic rdy,
                     input logic vld, input logic [W-1:0] ipc, input logic [W-1:0] ra, input logic mis);
    vec_t v;
    v.rst = rst; v.redir = redir; v.rpc = rpc; v.rdy = rdy;
    v.exp_vld = vld; v.exp_ipc = ipc; v.exp_ra = ra; v.exp_mis = mis;
    vecs.push_back(v);
  endtask

  task automatic step(input logic rst, input logic redir, input logic [W-1:0] rpc, input logic rdy);
    @(negedge clk);
    reset       = rst;
    redirect    = redir;
    redirect_pc = rpc;
    inst_ready  = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag, input vec_t v);
    chk({tag, " inst_valid"}, 32'(inst_valid), 32'(v.exp_vld));
    chk({tag, " rom_address"}, 32'(rom_address), 32'(v.exp_ra));
    chk({tag, " fetch_misaligned"}, 32'(fetch_misaligned), 32'(v.exp_mis));
    if (v.exp_vld) begin
      chk({tag, " inst_pc"}, 32'(inst_pc), 32'(v.exp_ipc));
      chk({tag, " inst"}, inst, 32'(v.exp_ipc >> 2));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t hv;
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b1;

    // rst redir rpc rdy | vld ipc ra mis
    // Streaming after reset: valid on the 2nd cycle, one word per cycle.
    add(0, 0, 16'h0, 1,  1, 16'h0000, 16'h0004, 0);
    add(0, 0, 16'h0, 1,  1, 16'h0004, 16'h0008, 0);
    add(0, 0, 16'h0, 1,  1, 16'h0008, 16'h000C, 0);
    add(0, 0, 16'h0, 1,  1, 16'h000C, 16'h0010, 0);
    // Fresh reset then ready low: FIFO fills to two, PC stalls at 8.
    add(1, 0, 16'h0, 0,  0, 16'h0000, 16'h0000, 0);
    add(0, 0, 16'h0, 0,  1, 16'h0000, 16'h0004, 0);
    add(0, 0, 16'h0, 0,  1, 16'h0000, 16'h0008, 0);
    add(0, 0, 16'h0, 0,  1, 16'h0000, 16'h0008, 0);
    add(0, 0, 16'h0, 0,  1, 16'h0000, 16'h0008, 0);
    add(0, 0, 16'h0, 0,  1, 16'h0000, 16'h0008, 0);
    add(0, 0, 16'h0, 1,  1, 16'h0004, 16'h000C, 0);
    add(0, 0, 16'h0, 1,  1, 16'h0008, 16'h0010, 0);
    // Redirect with 0x8/0xC queued: they must never be delivered.
    add(0, 1, 16'h0040, 1,  0, 16'h0000, 16'h0040, 0);
    add(0, 0, 16'h0, 1,  1, 16'h0040, 16'h0044, 0);
    add(0, 0, 16'h0, 1,  1, 16'h0044, 16'h0048, 0);
    // Fill, then reset mid-stream.
    add(0, 0, 16'h0, 0,  1, 16'h0044, 16'h004C, 0);
    add(1, 0, 16'h0, 0,  0, 16'h0000, 16'h0000, 0);
    add(0, 0, 16'h0, 1,  1, 16'h0000, 16'h0004, 0);
    // Redirect to the top word: PC wraps to zero.
    add(0, 1, 16'hFFFC, 1,  0, 16'h0000, 16'hFFFC, 0);
    add(0, 0, 16'h0, 1,  1, 16'hFFFC, 16'h0000, 0);
    add(0, 0, 16'h0, 1,  1, 16'h0000, 16'h0004, 0);
    add(0, 0, 16'h0, 1,  1, 16'h0004, 16'h0008, 0);
`ifdef FETCH_ALIGN_CHECK_EN
    add(0, 1, 16'h0042, 1,  0, 16'h0000, 16'h0042, 1);
    add(0, 0, 16'h0, 1,  0, 16'h0000, 16'h0042, 0);
    add(0, 0, 16'h0, 1,  0, 16'h0000, 16'h0042, 0);
    add(0, 1, 16'h0080, 1,  0, 16'h0000, 16'h0080, 0);
    add(0, 0, 16'h0, 1,  1, 16'h0080, 16'h0084, 0);
`else
    add(0, 1, 16'h0042, 1,  0, 16'h0000, 16'h0040, 0);
    add(0, 0, 16'h0, 1,  1, 16'h0040, 16'h0044, 0);
    add(0, 0, 16'h0, 1,  1, 16'h0044, 16'h0048, 0);
`endif

    // Reset state.
    step(1, 0, 16'h0, 1);
    step(1, 0, 16'h0, 1);
    chk("reset inst_valid", 32'(inst_valid), 32'h0);
    chk("reset inst", inst, 32'h0);
    chk("reset inst_pc", 32'(inst_pc), 32'h0);
    chk("reset rom_address", 32'(rom_address), 32'h0);
    chk("reset fetch_misaligned", 32'(fetch_misaligned), 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].redir, vecs[i].rpc, vecs[i].rdy);
      check_outputs($sformatf("vec%0d", i), vecs[i]);
    end

    // Back-to-back redirects: the last target wins.
    hv = '0;
    step(0, 1, 16'h0100, 1);
    hv.exp_ra = 16'h0100;
    check_outputs("b2b first", hv);
    step(0, 1, 16'h0200, 1);
    hv.exp_ra = 16'h0200;
    check_outputs("b2b second", hv);
    step(0, 0, 16'h0, 1);
    hv.exp_vld = 1'b1; hv.exp_ipc = 16'h0200; hv.exp_ra = 16'h0204;
    check_outputs("b2b deliver", hv);

    // Redirect while full and ready low, then ready held low: only the new word queues.
    step(0, 0, 16'h0, 0);
    hv.exp_ipc = 16'h0200; hv.exp_ra = 16'h0208;
    check_outputs("fill", hv);
    step(0, 1, 16'h0300, 0);
    hv.exp_vld = 1'b0; hv.exp_ra = 16'h0300;
    check_outputs("redir full", hv);
    step(0, 0, 16'h0, 0);
    hv.exp_vld = 1'b1; hv.exp_ipc = 16'h0300; hv.exp_ra = 16'h0304;
    check_outputs("post redir hold", hv);
    step(0, 0, 16'h0, 1);
    hv.exp_ipc = 16'h0304; hv.exp_ra = 16'h0308;
    check_outputs("post redir pop", hv);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
